// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the round stage
// and key-expansion logic.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_WORD_W  = 32;
  localparam int unsigned AES_BYTE_W  = 8;
  localparam int unsigned AES_CNT_W   = 4;

  localparam logic [AES_BYTE_W-1:0] AES_RCON_INIT = 8'h01;
  localparam logic [AES_BYTE_W-1:0] AES_RCON_LAST = 8'h36;
  localparam logic [AES_BYTE_W-1:0] AES_GF_POLY   = 8'h1B;

  typedef logic [AES_BLOCK_W-1:0] aes_state_t;
  typedef logic [AES_WORD_W-1:0]  aes_word_t;
  typedef logic [AES_BYTE_W-1:0]  aes_byte_t;

  // Round key viewed as four words, w0 in the most significant position
  typedef struct packed {
    aes_word_t w0;
    aes_word_t w1;
    aes_word_t w2;
    aes_word_t w3;
  } aes_key_words_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_HOLD  = 2'd2
  } aes_fsm_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_word.sv
// Combinational AES-128 round-key step: folds the upstream
// SubWord(RotWord(w3)) ^ Rcon word through the four key words.
module aes_key_expand_word
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] i_key,
  input  logic [AES_WORD_W-1:0]  i_key_word,
  output logic [AES_BLOCK_W-1:0] o_next_key_c
);

  aes_key_words_t w_cur;
  aes_key_words_t w_nxt;

  assign w_cur = aes_key_words_t'(i_key);

  // Each new word chains off the previous new word
  assign w_nxt.w0 = w_cur.w0 ^ i_key_word;
  assign w_nxt.w1 = w_cur.w1 ^ w_nxt.w0;
  assign w_nxt.w2 = w_cur.w2 ^ w_nxt.w1;
  assign w_nxt.w3 = w_cur.w3 ^ w_nxt.w2;

  assign o_next_key_c = AES_BLOCK_W'(w_nxt);

endmodule

// File: rtl/aes_round_stage.sv
// Iterative AES-128 round register: whitening on load, AddRoundKey and
// key-schedule completion each round, ciphertext held on a valid/ready port.
module aes_round_stage
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [AES_BLOCK_W-1:0] pt,
  input  logic [AES_BLOCK_W-1:0] key,
  output logic                   round_valid,
  output logic [AES_BLOCK_W-1:0] state_q,
  output logic [AES_BLOCK_W-1:0] key_q,
  output logic [AES_BYTE_W-1:0]  rcon_q,
  input  logic                   mix_valid,
  input  logic [AES_BLOCK_W-1:0] mix_state,
  input  logic [AES_WORD_W-1:0]  key_word,
  output logic                   ct_valid,
  input  logic                   ct_ready,
  output logic [AES_BLOCK_W-1:0] ct,
  output logic                   empty
);

  localparam logic [AES_CNT_W-1:0] LAST_ROUND = AES_CNT_W'(NUM_ROUNDS);

  aes_fsm_e               r_fsm;
  logic [AES_BLOCK_W-1:0] r_state;
  logic [AES_BLOCK_W-1:0] r_key;
  logic [AES_BYTE_W-1:0]  r_rcon;
  logic [AES_CNT_W-1:0]   r_round_cnt;
  logic                   r_load_ready;
  logic                   r_round_valid;
  logic                   r_ct_valid;
  logic                   r_empty;

  logic [AES_BLOCK_W-1:0] w_next_key;

  aes_key_expand_word u_key_expand (
    .i_key        (r_key),
    .i_key_word   (key_word),
    .o_next_key_c (w_next_key)
  );

  // Round loop; handshake flags are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm         <= ST_IDLE;
      r_state       <= '0;
      r_key         <= '0;
      r_rcon        <= '0;
      r_round_cnt   <= '0;
      r_load_ready  <= 1'b1;
      r_round_valid <= 1'b0;
      r_ct_valid    <= 1'b0;
      r_empty       <= 1'b1;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (load_valid) begin
            r_state       <= pt ^ key;
            r_key         <= key;
            r_rcon        <= AES_RCON_INIT;
            r_round_cnt   <= AES_CNT_W'(1);
            r_fsm         <= ST_ROUND;
            r_load_ready  <= 1'b0;
            r_empty       <= 1'b0;
            r_round_valid <= 1'b1;
          end
        end
        ST_ROUND: begin
          if (mix_valid) begin
            r_key   <= w_next_key;
            r_state <= mix_state ^ w_next_key;
            if (r_round_cnt == LAST_ROUND) begin
              r_fsm         <= ST_HOLD;
              r_round_valid <= 1'b0;
              r_ct_valid    <= 1'b1;
            end else begin
              r_round_cnt <= r_round_cnt + AES_CNT_W'(1);
              r_rcon      <= xtime(r_rcon);
            end
          end
        end
        ST_HOLD: begin
          // State and key are left in place after the handshake
          if (ct_ready) begin
            r_fsm        <= ST_IDLE;
            r_ct_valid   <= 1'b0;
            r_load_ready <= 1'b1;
            r_empty      <= 1'b1;
          end
        end
        default: begin
          r_fsm         <= ST_IDLE;
          r_load_ready  <= 1'b1;
          r_round_valid <= 1'b0;
          r_ct_valid    <= 1'b0;
          r_empty       <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready  = r_load_ready;
  assign round_valid = r_round_valid;
  assign ct_valid    = r_ct_valid;
  assign empty       = r_empty;
  assign state_q     = r_state;
  assign key_q       = r_key;
  assign rcon_q      = r_rcon;
  assign ct          = r_state;

endmodule

// File: tb/tb_aes_round_stage.sv
// Scoreboarded bench for aes_round_stage with a golden SubBytes/ShiftRows/
// MixColumns upstream model and FIPS-197 directed vectors.
module tb_aes_round_stage;

  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_B10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_C   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic         load_ready;
  logic [127:0] pt;
  logic [127:0] key;
  logic         round_valid;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [7:0]   rcon_q;
  logic         mix_valid;
  logic [127:0] mix_state;
  logic [31:0]  key_word;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] ct;
  logic         empty;

  always #5 clk = ~clk;

  aes_round_stage #(.NUM_ROUNDS(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .pt          (pt),
    .key         (key),
    .round_valid (round_valid),
    .state_q     (state_q),
    .key_q       (key_q),
    .rcon_q      (rcon_q),
    .mix_valid   (mix_valid),
    .mix_state   (mix_state),
    .key_word    (key_word),
    .ct_valid    (ct_valid),
    .ct_ready    (ct_ready),
    .ct          (ct),
    .empty       (empty)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] key;
    bit           chk_key;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // ---------------- golden upstream model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  initial for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
  endfunction

  function automatic logic [127:0] up_round(input logic [127:0] s, input bit last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   x0, x1, x2, x3;
    logic [127:0] res;
    res = '0;
    for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        b[rr+4*c] = a[rr + 4*((c + rr) % 4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = gmul(x0, 8'h02) ^ gmul(x1, 8'h03) ^ x2 ^ x3;
        b[4*c+1] = x0 ^ gmul(x1, 8'h02) ^ gmul(x2, 8'h03) ^ x3;
        b[4*c+2] = x0 ^ x1 ^ gmul(x2, 8'h02) ^ gmul(x3, 8'h03);
        b[4*c+3] = gmul(x0, 8'h03) ^ x1 ^ x2 ^ gmul(x3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = b[i];
    return res;
  endfunction

  int           up_mode = 0;  // 0: directed override, 1: golden model
  bit           stall_en = 1'b0;
  logic         ovr_valid = 1'b0;
  logic [127:0] ovr_state = '0;
  logic [31:0]  ovr_word = '0;

  always @(posedge clk) begin
    #2;
    if (up_mode == 1) begin
      mix_valid = round_valid && !(stall_en && ($urandom_range(0, 2) == 0));
      mix_state = up_round(state_q, rcon_q == 8'h36);
      key_word  = sub_rot_word(key_q[31:0]) ^ {rcon_q, 24'h0};
    end else begin
      mix_valid = ovr_valid;
      mix_state = ovr_state;
      key_word  = ovr_word;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && ct_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ct: got ct_valid=1 ct=%h required no pending output", ct);
      end else begin
        check("ct", ct, sb_q[0].ct);
        if (sb_q[0].chk_key) check("final_key_q", key_q, sb_q[0].key);
        if (ct_ready) sb_q.delete(0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_load(input logic [127:0] p, input logic [127:0] k);
    int n;
    n = 0;
    while (!load_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("load_ready", 128'(load_ready), 128'(1'b1));
    pt = p;
    key = k;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_ct(input int max);
    int n;
    n = 0;
    while (!ct_valid && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ct_valid) begin
      checks++;
      errors++;
      $display("FAIL ct_timeout: got ct_valid=0 after %0d cycles required 1", max);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state_q"},     state_q,                  128'h0);
    check({tag, "_key_q"},       key_q,                    128'h0);
    check({tag, "_ct"},          ct,                       128'h0);
    check({tag, "_rcon_q"},      128'(rcon_q),             128'h0);
    check({tag, "_round_valid"}, 128'(round_valid),        128'h0);
    check({tag, "_ct_valid"},    128'(ct_valid),           128'h0);
    check({tag, "_load_ready"},  128'(load_ready),         128'h1);
    check({tag, "_empty"},       128'(empty),              128'h1);
  endtask

  logic [7:0] rcon_seq [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  initial begin
    int n;
    bit saw;
    rst = 1'b0; load_valid = 1'b0; pt = '0; key = '0; ct_ready = 1'b0;
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Key path in isolation: zero mix_state, FIPS round-1 key word
    do_load(128'h0, KEY_B);
    check("whiten_state", state_q, KEY_B);
    check("rcon_init", 128'(rcon_q), 128'h01);
    ovr_state = '0; ovr_word = 32'h8b84eb01; ovr_valid = 1'b1;
    @(posedge clk); #1;
    ovr_valid = 1'b0;
    check("key_path_state", state_q, KEY_B1);
    check("key_path_key", key_q, KEY_B1);
    check("key_path_rcon", 128'(rcon_q), 128'h02);
    pt = '1; key = '1; load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    check("round_hold_state", state_q, KEY_B1);
    check("round_ignore_load", 128'(rcon_q), 128'h02);
    #2 rst = 1'b1;
    #1 check("pulse_rst_round_valid", 128'(round_valid), 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 App. B with combinational upstream, latency check
    up_mode = 1; ct_ready = 1'b1;
    sb_q.push_back('{ct: CT_B, key: KEY_B10, chk_key: 1'b1});
    do_load(PT_B, KEY_B);
    n = 0;
    while (!ct_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency_edges", 128'(n), 128'd10);
    @(posedge clk); #1;
    check("after_hs_empty", 128'(empty), 128'h1);
    check("after_hs_state", state_q, CT_B);
    check("after_hs_key", key_q, KEY_B10);

    // mix_valid in IDLE must be ignored
    up_mode = 0; ct_ready = 1'b0;
    ovr_state = 128'h5a5a_0f0f_1234_5678_9abc_def0_1357_9bdf; ovr_word = 32'h1234_5678;
    ovr_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_mix_state", state_q, CT_B);
    check("idle_mix_key", key_q, KEY_B10);

    // Rcon sequence with mix_valid held high (zero key keeps everything zero)
    ovr_state = '0; ovr_word = '0;
    sb_q.push_back('{ct: 128'h0, key: 128'h0, chk_key: 1'b1});
    do_load(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 128'h0);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("rcon_r%0d", k + 1), 128'(rcon_q), 128'(rcon_seq[k]));
      check($sformatf("round_valid_r%0d", k + 1), 128'(round_valid), 128'h1);
      @(posedge clk); #1;
    end
    check("rcon_ct_valid", 128'(ct_valid), 128'h1);
    check("rcon_round_valid_off", 128'(round_valid), 128'h0);
    check("rcon_last_held", 128'(rcon_q), 128'h36);
    ovr_state = 128'hdead_beef_0bad_f00d_cafe_babe_1111_2222; ovr_word = 32'hcafe_f00d;
    repeat (3) @(posedge clk);
    #1;
    check("hold_mix_state", state_q, 128'h0);
    ovr_valid = 1'b0; ct_ready = 1'b1;
    @(posedge clk); #1;
    ct_ready = 1'b0;
    check("rcon_blk_empty", 128'(empty), 128'h1);

    // FIPS-197 App. C.1 with stalls, held output, loads offered throughout
    up_mode = 1; stall_en = 1'b1;
    sb_q.push_back('{ct: CT_C, key: 128'h0, chk_key: 1'b0});
    do_load(PT_C, KEY_C);
    pt = '1; key = '1; load_valid = 1'b1;
    wait_ct(200);
    repeat (5) @(posedge clk);
    #1;
    ct_ready = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0; ct_ready = 1'b0; stall_en = 1'b0;
    check("hs_load_ignored_idle", 128'(load_ready), 128'h1);
    check("hs_load_ignored_state", state_q, CT_C);
    check("hs_load_ignored_rv", 128'(round_valid), 128'h0);

    // Reset in round 5, then a clean block
    ct_ready = 1'b1;
    sb_q.push_back('{ct: CT_B, key: KEY_B10, chk_key: 1'b1});
    do_load(PT_B, KEY_B);
    n = 0;
    while (rcon_q != 8'h10 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_round5", 128'(rcon_q), 128'h10);
    #2 rst = 1'b1;
    #1 check_reset("midrst");
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ct_valid) saw = 1'b1;
    end
    check("no_ct_after_rst", 128'(saw), 128'h0);
    sb_q.push_back('{ct: CT_B, key: KEY_B10, chk_key: 1'b1});
    do_load(PT_B, KEY_B);
    wait_ct(40);
    n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("sb_drained", 128'(sb_q.size()), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 time units required finish");
    $fatal(1);
  end

endmodule
